event_count_accumulator: RTL

Downstream consumer of the per-cycle pulse/pileup count stream produced by the event-analysis stage. It integrates the counts over a programmable window of valid cycles. Each completed window is emitted as a record through a small FIFO with a valid/ready handshake, for readout or DMA logic. Acquisition is gated by start/stop commands, and partial windows are flushed on stop.

---
 rtl/evt_acc_pkg.sv | 29 ++
 rtl/evt_rec_fifo.sv | 55 +++++
 rtl/event_count_accumulator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/evt_acc_pkg.sv
// Shared definitions for the event count accumulator: FSM states, field
// widths and the packed record width.
// Optional feature macro: EVT_ACC_PEAK_EN (adds a per-window peak pulse field).
package evt_acc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int PULSE_W   = 5;
   localparam int IDX_W     = 16;
   localparam int DEF_CNT_W = 32;

`ifdef EVT_ACC_PEAK_EN
   localparam int PEAK_EXTRA_W = PULSE_W;
`else
   localparam int PEAK_EXTRA_W = 0;
`endif

   // Record layout, MSB to LSB: pulse total, pileup total, window index,
   // partial flag and, when enabled, the peak pulse value.
   function automatic int rec_w(input int cnt_w);
      return 2 * cnt_w + IDX_W + 1 + PEAK_EXTRA_W;
   endfunction

   localparam int REC_W = rec_w(DEF_CNT_W);

endpackage

// File: rtl/evt_rec_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is
// always visible on o_rd_data; a read is honoured only when non-empty and a
// write is honoured when not full or when a read frees a slot on the same edge.
module evt_rec_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_do_rd;
   logic              w_do_wr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_rd   = i_rd_en && !o_empty;
   assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   // Advance read and write pointers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Write the storage array.
   // NOTE: the storage is deliberately not reset; the pointers define which
   // entries are meaningful, and leaving the array out of reset keeps it a
   // plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/event_count_accumulator.sv
// Integrates per-cycle pulse/pileup counts over a programmable window of
// valid beats and queues one record per window through a FWFT FIFO.
// A stop command flushes a non-empty partial window as a partial record.
// Optional feature macro: EVT_ACC_PEAK_EN (adds rec_peak_pulse).
module event_count_accumulator
   import evt_acc_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int WIN_W      = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [WIN_W-1:0]   window_len,
   input  logic               valid_in,
   input  logic [PULSE_W-1:0] pulse_this_cycle,
   input  logic [PULSE_W-1:0] pileup_this_cycle,
   output logic               rec_valid,
   input  logic               rec_ready,
   output logic [CNT_W-1:0]   rec_pulse_total,
   output logic [CNT_W-1:0]   rec_pileup_total,
   output logic [IDX_W-1:0]   rec_window_idx,
   output logic               rec_partial,
`ifdef EVT_ACC_PEAK_EN
   output logic [PULSE_W-1:0] rec_peak_pulse,
`endif
   output logic               busy,
   output logic [15:0]        drop_count
);

   localparam int RW   = rec_w(CNT_W);
   localparam int PK_W = PEAK_EXTRA_W;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_enter_run;

   logic [WIN_W-1:0]  r_len;
   logic [WIN_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_pulse_acc;
   logic [CNT_W-1:0]  r_pileup_acc;
   logic [IDX_W-1:0]  r_idx;
   logic [15:0]       r_drop;

   logic              w_beat;
   logic              w_close;
   logic              w_flush;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic [CNT_W-1:0]  w_pulse_win;
   logic [CNT_W-1:0]  w_pileup_win;
   logic [RW-1:0]     w_rec_in;
   logic [RW-1:0]     w_fifo_head;
   logic [RW-1:0]     w_rec_out;
   logic              w_full;
   logic              w_empty;

`ifdef EVT_ACC_PEAK_EN
   logic [PULSE_W-1:0] r_peak;
   logic [PULSE_W-1:0] w_peak_win;
`endif

   // Saturating accumulate of a zero-extended beat count.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0]   acc,
                                                input logic [PULSE_W-1:0] val);
      logic [CNT_W:0] sum;
      sum = {1'b0, acc} + (CNT_W+1)'(val);
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next-state: start wins in IDLE, stop ends RUN.
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_enter_run = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
               w_enter_run = 1'b1;
            end
         end
         RUN: begin
            if (stop) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign busy = (r_state == RUN);

   // Window bookkeeping; the window totals include the current beat so a
   // closing or flushing record never loses it.
   assign w_beat       = busy && valid_in;
   assign w_pulse_win  = w_beat ? sat_add(r_pulse_acc, pulse_this_cycle)   : r_pulse_acc;
   assign w_pileup_win = w_beat ? sat_add(r_pileup_acc, pileup_this_cycle) : r_pileup_acc;
   assign w_close      = w_beat && (r_cnt == r_len - WIN_W'(1));
   assign w_flush      = busy && stop && !w_close && ((r_cnt != '0) || w_beat);
   assign w_push       = w_close || w_flush;
   assign w_pop        = rec_valid && rec_ready;
   assign w_drop       = w_push && w_full && !w_pop;

`ifdef EVT_ACC_PEAK_EN
   assign w_peak_win = (w_beat && (pulse_this_cycle > r_peak)) ? pulse_this_cycle : r_peak;
   assign w_rec_in   = {w_pulse_win, w_pileup_win, r_idx, ~w_close, w_peak_win};
`else
   assign w_rec_in   = {w_pulse_win, w_pileup_win, r_idx, ~w_close};
`endif

   // Accumulators, beat counter, window index and drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len        <= '0;
         r_cnt        <= '0;
         r_pulse_acc  <= '0;
         r_pileup_acc <= '0;
         r_idx        <= '0;
         r_drop       <= '0;
      end else if (w_enter_run) begin
         r_len        <= (window_len == '0) ? WIN_W'(1) : window_len;
         r_cnt        <= '0;
         r_pulse_acc  <= '0;
         r_pileup_acc <= '0;
         r_idx        <= '0;
         r_drop       <= '0;
      end else if (busy) begin
         if (w_close || stop) begin
            r_cnt        <= '0;
            r_pulse_acc  <= '0;
            r_pileup_acc <= '0;
         end else if (w_beat) begin
            r_cnt        <= r_cnt + WIN_W'(1);
            r_pulse_acc  <= w_pulse_win;
            r_pileup_acc <= w_pileup_win;
         end
         if (w_push)                   r_idx  <= r_idx + IDX_W'(1);
         if (w_drop && (r_drop != '1)) r_drop <= r_drop + 16'd1;
      end
   end

`ifdef EVT_ACC_PEAK_EN
   // Running per-window maximum of pulse_this_cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_peak <= '0;
      else if (w_enter_run)                r_peak <= '0;
      else if (busy && (w_close || stop))  r_peak <= '0;
      else if (w_beat)                     r_peak <= w_peak_win;
   end
`endif

   evt_rec_fifo #(
      .DATA_W (RW),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_push),
      .i_wr_data (w_rec_in),
      .i_rd_en   (rec_ready),
      .o_rd_data (w_fifo_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Present zeros while empty so record fields are clean after reset.
   assign w_rec_out        = w_empty ? '0 : w_fifo_head;
   assign rec_valid        = !w_empty;
   assign rec_partial      = w_rec_out[PK_W];
   assign rec_window_idx   = w_rec_out[PK_W+1 +: IDX_W];
   assign rec_pileup_total = w_rec_out[PK_W+1+IDX_W +: CNT_W];
   assign rec_pulse_total  = w_rec_out[PK_W+1+IDX_W+CNT_W +: CNT_W];
`ifdef EVT_ACC_PEAK_EN
   assign rec_peak_pulse   = w_rec_out[0 +: PULSE_W];
`endif
   assign drop_count       = r_drop;

endmodule
